// File: rtl/uart_rx_if.sv
// uart_rx_if -- serial-side and byte-side signals of the UART receiver.
//   s_tick        baud oversample strobe (16 per bit period, one clk wide)
//   rx            serial line, idle high, asynchronous to clk
//   dout          received byte, zero-extended when fewer than 8 data bits
//   rx_done_tick  one-cycle strobe: frame complete, dout valid
//   frame_err     qualifies rx_done_tick: stop bit read low
// master drives the line and tick (pin/baud side), slave is the receiver.
interface uart_rx_if;
    logic       s_tick;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    modport master (
        output s_tick, rx,
        input  dout, rx_done_tick, frame_err
    );

    modport slave (
        input  s_tick, rx,
        output dout, rx_done_tick, frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 16x oversampled UART receiver: 1 start bit, DBIT data bits
// (LSB first), no parity, stop bit of SB_TICK oversample ticks.
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    uart_rx_if.slave: s_tick/rx in, dout/rx_done_tick/frame_err out
// One byte plus a one-cycle rx_done_tick per frame; frame_err rides on the
// strobe when the stop bit samples low. A frame with a bad stop bit still
// updates dout and still strobes.
module uart_rx #(
    parameter int DBIT    = 8,   // data bits per frame, 5..8
    parameter int SB_TICK = 16   // ticks spent in the stop bit (16/24/32)
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    // s must be able to reach SB_TICK-1 in the stop bit.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    localparam logic [SW-1:0] S_MID_START = SW'(7);
    localparam logic [SW-1:0] S_MID_DATA  = SW'(15);
    localparam logic [SW-1:0] S_STOP_END  = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [SW-1:0] s;
    logic [2:0]    n;
    logic [7:0]    b;
    logic          done_q;
    logic          ferr_q;

    // Two-flop synchronizer as a small shift register; resets to the idle
    // level so a reset release never looks like a start edge.
    logic [1:0] rx_pipe;
    logic       rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_pipe <= 2'b11;
        else       rx_pipe <= {rx_pipe[0], bus.rx};
    end

    assign rx_s = rx_pipe[1];

    // Receiver FSM. s counts ticks within the current bit, n counts data
    // bits, b shifts in from the top so the first bit ends up in b[8-DBIT].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            s      <= '0;
            n      <= '0;
            b      <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (bus.s_tick) begin
                        if (s == S_MID_START) begin
                            // Line must still be low mid start bit, else it
                            // was a glitch and we drop back silently.
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (bus.s_tick) begin
                        if (s == S_MID_DATA) begin
                            b <= {rx_s, b[7:1]};
                            s <= '0;
                            if (n == N_LAST) state <= STOP;
                            else             n     <= n + 3'd1;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (bus.s_tick) begin
                        if (s == S_STOP_END) begin
                            // Counting from mid last data bit lands mid stop
                            // bit, so the next start edge can be caught early.
                            state  <= IDLE;
                            done_q <= 1'b1;
                            ferr_q <= ~rx_s;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Right-align the DBIT received bits; upper bits fall out as zero.
    assign bus.dout         = b >> (8 - DBIT);
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = ferr_q;

endmodule
